axil_decerr_slave_wr: RTL and testbench
=======================================

AXIL_DECERR_SLAVE_WR -- requirements
Module: axil_decerr_slave_wr

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning data width in bits (multiple of 8).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning address width in bits.
REQ-003 SHALL have parameter ERR_RESP, default 2'b11, meaning response code returned on B (DECERR).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning width of the error counter (used only with AXIL_DECERR_STATS_EN).
REQ-005 aclk  input  1  single clock, all logic on rising edge.
REQ-006 areset  input  1  reset: synchronous, active-high.
REQ-007 s_axil_awaddr  input  AXI_ADDR_WIDTH  write address from the interconnect unmapped-address slot.
REQ-008 s_axil_awvalid  input  1  / s_axil_awready  output  1  AW handshake.
REQ-009 s_axil_wdata  input  AXI_DATA_WIDTH  / s_axil_wstrb  input  AXI_DATA_WIDTH/8  write data and strobes, discarded.
REQ-010 s_axil_wvalid  input  1  / s_axil_wready  output  1  W handshake.
REQ-011 s_axil_bresp  output  2  / s_axil_bvalid  output  1  / s_axil_bready  input  1  B channel.
REQ-012 err_count  output  CNT_WIDTH  / last_err_addr  output  AXI_ADDR_WIDTH  / err_pulse  output  1  statistics (present only with AXIL_DECERR_STATS_EN).

Function
REQ-013 SHALL be a terminating write slave placed on the interconnect's extra slave slot: accepts any write and answers with ERR_RESP, never stalling the interconnect indefinitely.
REQ-014 SHALL implement FSM states IDLE, WAIT_W (AW taken), WAIT_AW (W taken), RESP.
REQ-015 s_axil_awready SHALL be 1 in IDLE and WAIT_AW, else 0; s_axil_wready SHALL be 1 in IDLE and WAIT_W, else 0 (decoded from registered state, no input-to-ready paths).
REQ-016 IDLE: AW and W handshakes in same cycle -> RESP; AW only -> WAIT_W; W only -> WAIT_AW; neither -> IDLE.
REQ-017 WAIT_W on W handshake -> RESP; WAIT_AW on AW handshake -> RESP; otherwise hold.
REQ-018 s_axil_bvalid SHALL be registered, 1 exactly in RESP; first assertion the cycle after the completing handshake (latency 1 cycle from last of AW/W).
REQ-019 s_axil_bresp SHALL equal ERR_RESP while bvalid=1 and 2'b00 otherwise.
REQ-020 RESP: bvalid held and bresp stable until s_axil_bready=1; on handshake -> IDLE; no new AW/W accepted in RESP (one outstanding transaction).
REQ-021 bready=1 while bvalid=0 SHALL have no effect; awvalid/wvalid deasserting without handshake SHALL not change state.
REQ-022 wdata/wstrb SHALL be ignored; no storage of write data.

Reset
REQ-023 areset=1 at a rising edge SHALL force state IDLE, bvalid=0, bresp=2'b00, err_count=0, last_err_addr=0, err_pulse=0, regardless of state (including mid-transaction in WAIT_W/WAIT_AW/RESP; pending response is dropped).
REQ-024 During reset cycles awready and wready SHALL be 0; they rise the first cycle after areset deasserts.

Configuration
REQ-025 Macro AXIL_DECERR_STATS_EN SHALL, when defined, include err_count, last_err_addr and err_pulse ports and logic; when undefined those ports and registers SHALL not exist and the write FSM behaviour SHALL be identical.
REQ-026 With AXIL_DECERR_STATS_EN: last_err_addr SHALL load s_axil_awaddr on every AW handshake; err_count SHALL increment by 1 on every B handshake, saturating at all-ones (no wrap); err_pulse SHALL be 1 for exactly the cycle after each B handshake.

Verification
REQ-027 Reset then AW (addr 0x0000_F000) and W same cycle, bready=1 -> bvalid=1 next cycle with bresp=2'b11, bvalid=0 the cycle after, err_count=1, last_err_addr=0x0000_F000.
REQ-028 AW at cycle 0, W at cycle 3 -> awready=0 and wready=1 during cycles 1-3, bvalid first high at cycle 4.
REQ-029 W first, AW 2 cycles later, bready held 0 for 5 cycles -> bvalid and bresp=2'b11 stable all 5 cycles, awready=wready=0 throughout, single B handshake on bready.
REQ-030 areset pulsed while in RESP -> bvalid=0 next cycle, state IDLE, err_count=0; following write completes normally.
REQ-031 CNT_WIDTH=4, 17 back-to-back writes -> err_count reaches 4'hF and stays; err_pulse seen 17 times.
REQ-032 Build without AXIL_DECERR_STATS_EN, repeat REQ-027 stimulus -> identical B-channel timing and values.

Source files
------------

// File: rtl/axil_decerr_slave_wr.sv
// Terminating AXI4-Lite write slave: accepts every write and answers with ERR_RESP.
// Optional statistics (err_count, last_err_addr, err_pulse) are built when AXIL_DECERR_STATS_EN is defined.
module axil_decerr_slave_wr #(
  parameter int         AXI_DATA_WIDTH = 32,
  parameter int         AXI_ADDR_WIDTH = 32,
  parameter logic [1:0] ERR_RESP       = 2'b11,
  parameter int         CNT_WIDTH      = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready
`ifdef AXIL_DECERR_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]        err_count,
  output logic [AXI_ADDR_WIDTH-1:0]   last_err_addr,
  output logic                        err_pulse
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_W  = 2'd1,
    WAIT_AW = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       ready_en_q;
  logic       bvalid_q;
  logic [1:0] bresp_q;

  logic aw_hs;
  logic w_hs;
  logic b_hs;

  // Readies come from registered state only; ready_en_q holds them low while
  // in reset and for the cycle in which reset is still being sampled.
  assign s_axil_awready = ready_en_q && ((state_q == IDLE) || (state_q == WAIT_AW));
  assign s_axil_wready  = ready_en_q && ((state_q == IDLE) || (state_q == WAIT_W));
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;

  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid  && s_axil_wready;
  assign b_hs  = bvalid_q       && s_axil_bready;

  // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs) state_d = RESP;
        else if (aw_hs)    state_d = WAIT_W;
        else if (w_hs)     state_d = WAIT_AW;
      end
      WAIT_W:  if (w_hs)  state_d = RESP;
      WAIT_AW: if (aw_hs) state_d = RESP;
      RESP:    if (b_hs)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      bvalid_q   <= (state_d == RESP);
      bresp_q    <= (state_d == RESP) ? ERR_RESP : 2'b00;
    end
  end

`ifdef AXIL_DECERR_STATS_EN
  logic [CNT_WIDTH-1:0]      err_count_q;
  logic [AXI_ADDR_WIDTH-1:0] last_err_addr_q;
  logic                      err_pulse_q;

  assign err_count     = err_count_q;
  assign last_err_addr = last_err_addr_q;
  assign err_pulse     = err_pulse_q;

  // The counter saturates so a long-running error storm never reads back as a small number.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_count_q     <= '0;
      last_err_addr_q <= '0;
      err_pulse_q     <= 1'b0;
    end else begin
      err_pulse_q <= b_hs;
      if (b_hs && (err_count_q != {CNT_WIDTH{1'b1}})) begin
        err_count_q <= err_count_q + CNT_WIDTH'(1);
      end
      if (aw_hs) begin
        last_err_addr_q <= s_axil_awaddr;
      end
    end
  end

  logic unused_data;
  assign unused_data = ^{s_axil_wdata, s_axil_wstrb};
`else
  logic                 unused_data;
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_data = ^{s_axil_wdata, s_axil_wstrb, s_axil_awaddr};
  assign unused_cnt  = '0;
`endif

endmodule

// File: tb/tb_axil_decerr_slave_wr.sv
// Self-checking bench for axil_decerr_slave_wr: directed scenarios plus randomized traffic
// against a transaction-level model (outstanding AW/W flags, one pending response).
module tb_axil_decerr_slave_wr;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
`ifdef AXIL_DECERR_STATS_EN
  logic [CW-1:0] err_count;
  logic [AW-1:0] last_err_addr;
  logic          err_pulse;
`endif

  int checks = 0;
  int fails  = 0;

  axil_decerr_slave_wr #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .CNT_WIDTH     (CW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axil_awaddr (awaddr),
    .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata  (wdata),
    .s_axil_wstrb  (wstrb),
    .s_axil_wvalid (wvalid),
    .s_axil_wready (wready),
    .s_axil_bresp  (bresp),
    .s_axil_bvalid (bvalid),
    .s_axil_bready (bready)
`ifdef AXIL_DECERR_STATS_EN
    ,
    .err_count     (err_count),
    .last_err_addr (last_err_addr),
    .err_pulse     (err_pulse)
`endif
  );

  always #5 aclk = ~aclk;

  // Transaction-level reference model.
  bit          m_ready_en = 1'b0;
  bit          m_aw_got   = 1'b0;
  bit          m_w_got    = 1'b0;
  bit          m_resp     = 1'b0;
  bit          m_pulse    = 1'b0;
  logic [CW-1:0] m_cnt  = '0;
  logic [AW-1:0] m_addr = '0;

  function automatic logic [4:0] exp_bus();
    bit can_take;
    can_take = m_ready_en && !m_resp;
    return {can_take && !m_aw_got, can_take && !m_w_got, m_resp, (m_resp ? 2'b11 : 2'b00)};
  endfunction

  task automatic drive(input bit rst, input bit awv, input logic [AW-1:0] addr,
                       input bit wv, input bit br);
    areset  = rst;
    awvalid = awv;
    awaddr  = addr;
    wvalid  = wv;
    wdata   = $urandom;
    wstrb   = 4'($urandom);
    bready  = br;
  endtask

  // Advance one clock and update the model from the inputs presented in that cycle.
  task automatic step();
    bit            aw_hs, w_hs, b_hs;
    logic [AW-1:0] addr;
    aw_hs = awvalid && m_ready_en && !m_resp && !m_aw_got;
    w_hs  = wvalid  && m_ready_en && !m_resp && !m_w_got;
    b_hs  = m_resp && bready;
    addr  = awaddr;
    @(posedge aclk);
    if (areset) begin
      m_ready_en = 1'b0; m_aw_got = 1'b0; m_w_got = 1'b0; m_resp = 1'b0;
      m_pulse = 1'b0; m_cnt = '0; m_addr = '0;
    end else begin
      m_pulse = b_hs;
      if (b_hs && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (aw_hs) m_addr = addr;
      if (b_hs) begin
        m_resp = 1'b0;
      end else if ((m_aw_got || aw_hs) && (m_w_got || w_hs)) begin
        m_resp = 1'b1; m_aw_got = 1'b0; m_w_got = 1'b0;
      end else begin
        m_aw_got = m_aw_got || aw_hs;
        m_w_got  = m_w_got  || w_hs;
      end
      m_ready_en = 1'b1;
    end
    @(negedge aclk);
  endtask

  task automatic test_reset();
    drive(1, 1, 32'hDEAD_0000, 1, 1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({awready, wready, bvalid, bresp} !== 5'b00000) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: got %b want 00000", i, {awready, wready, bvalid, bresp});
      end
      step();
    end
    drive(0, 0, '0, 0, 0);
    checks++;
    if ({awready, wready, bvalid, bresp} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_release_same: got %b want 00000", {awready, wready, bvalid, bresp});
    end
    step();
    checks++;
    if ({awready, wready, bvalid, bresp} !== 5'b11000) begin
      fails++;
      $display("FAIL reset_release_next: got %b want 11000", {awready, wready, bvalid, bresp});
    end
`ifdef AXIL_DECERR_STATS_EN
    checks++;
    if ({err_count, last_err_addr, err_pulse} !== '0) begin
      fails++;
      $display("FAIL reset_stats: cnt=%0d addr=%h pulse=%b want zeros", err_count, last_err_addr, err_pulse);
    end
`endif
  endtask

  task automatic test_same_cycle();
    drive(0, 1, 32'h0000_F000, 1, 1);
    step();
    drive(0, 0, '0, 0, 1);
    checks++;
    if ({awready, wready, bvalid, bresp} !== 5'b00111) begin
      fails++;
      $display("FAIL same_cycle_b: got %b want 00111", {awready, wready, bvalid, bresp});
    end
    step();
    checks++;
    if ({awready, wready, bvalid, bresp} !== 5'b11000) begin
      fails++;
      $display("FAIL same_cycle_after: got %b want 11000", {awready, wready, bvalid, bresp});
    end
`ifdef AXIL_DECERR_STATS_EN
    checks++;
    if ({err_count, last_err_addr, err_pulse} !== {4'd1, 32'h0000_F000, 1'b1}) begin
      fails++;
      $display("FAIL same_cycle_stats: cnt=%0d addr=%h pulse=%b want 1 0000f000 1", err_count, last_err_addr, err_pulse);
    end
`endif
  endtask

  task automatic test_aw_then_w();
    drive(0, 1, 32'h0000_1234, 0, 1);
    step();
    for (int c = 1; c <= 3; c++) begin
      drive(0, 0, '0, (c == 3), 1);
      checks++;
      if ({awready, wready, bvalid} !== 3'b010) begin
        fails++;
        $display("FAIL aw_then_w_wait cyc%0d: got %b want 010", c, {awready, wready, bvalid});
      end
      step();
    end
    drive(0, 0, '0, 0, 1);
    checks++;
    if ({awready, wready, bvalid, bresp} !== 5'b00111) begin
      fails++;
      $display("FAIL aw_then_w_b cyc4: got %b want 00111", {awready, wready, bvalid, bresp});
    end
    step();
    checks++;
    if ({awready, wready, bvalid, bresp} !== exp_bus()) begin
      fails++;
      $display("FAIL aw_then_w_done: got %b want %b", {awready, wready, bvalid, bresp}, exp_bus());
    end
  endtask

  task automatic test_w_then_aw_stall();
    drive(0, 0, '0, 1, 0);
    step();
    for (int c = 1; c <= 2; c++) begin
      drive(0, (c == 2), 32'h0000_0ABC, 0, 0);
      checks++;
      if ({awready, wready, bvalid} !== 3'b100) begin
        fails++;
        $display("FAIL w_then_aw_wait cyc%0d: got %b want 100", c, {awready, wready, bvalid});
      end
      step();
    end
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 32'($urandom), 1, (c == 5));
      checks++;
      if ({awready, wready, bvalid, bresp} !== 5'b00111) begin
        fails++;
        $display("FAIL w_then_aw_stall cyc%0d: got %b want 00111", c, {awready, wready, bvalid, bresp});
      end
      step();
    end
    drive(0, 0, '0, 0, 1);
    checks++;
    if ({awready, wready, bvalid, bresp} !== 5'b11000) begin
      fails++;
      $display("FAIL w_then_aw_single_b: got %b want 11000", {awready, wready, bvalid, bresp});
    end
`ifdef AXIL_DECERR_STATS_EN
    checks++;
    if ({err_count, last_err_addr, err_pulse} !== {4'd3, 32'h0000_0ABC, 1'b1}) begin
      fails++;
      $display("FAIL w_then_aw_stats: cnt=%0d addr=%h pulse=%b want 3 00000abc 1", err_count, last_err_addr, err_pulse);
    end
`endif
  endtask

  task automatic test_reset_in_resp();
    drive(0, 1, 32'h0000_5000, 1, 0);
    step();
    drive(1, 0, '0, 0, 0);
    checks++;
    if ({awready, wready, bvalid, bresp} !== 5'b00111) begin
      fails++;
      $display("FAIL reset_in_resp_pre: got %b want 00111", {awready, wready, bvalid, bresp});
    end
    step();
    drive(0, 0, '0, 0, 1);
    checks++;
    if ({awready, wready, bvalid, bresp} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_in_resp_post: got %b want 00000", {awready, wready, bvalid, bresp});
    end
`ifdef AXIL_DECERR_STATS_EN
    checks++;
    if (err_count !== 4'd0) begin
      fails++;
      $display("FAIL reset_in_resp_cnt: got %0d want 0", err_count);
    end
`endif
    step();
    drive(0, 1, 32'h0000_6000, 1, 1);
    step();
    drive(0, 0, '0, 0, 1);
    checks++;
    if ({awready, wready, bvalid, bresp} !== exp_bus()) begin
      fails++;
      $display("FAIL reset_in_resp_next_b: got %b want %b", {awready, wready, bvalid, bresp}, exp_bus());
    end
    step();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    drive(1, 0, '0, 0, 0);
    step();
    drive(0, 0, '0, 0, 0);
    step();
    for (int n = 0; n < 17; n++) begin
      for (int ph = 0; ph < 2; ph++) begin
        drive(0, (ph == 0), 32'($urandom), (ph == 0), 1);
        checks++;
        if ({awready, wready, bvalid, bresp} !== exp_bus()) begin
          fails++;
          $display("FAIL b2b n%0d ph%0d: got %b want %b", n, ph, {awready, wready, bvalid, bresp}, exp_bus());
        end
`ifdef AXIL_DECERR_STATS_EN
        if (err_pulse === 1'b1) pulses++;
`endif
        step();
      end
    end
`ifdef AXIL_DECERR_STATS_EN
    if (err_pulse === 1'b1) pulses++;
    checks++;
    if (err_count !== 4'hF || pulses != 17) begin
      fails++;
      $display("FAIL b2b_saturate: cnt=%h pulses=%0d want F 17", err_count, pulses);
    end
    drive(0, 1, '0, 1, 1);
    step();
    step();
    checks++;
    if (err_count !== 4'hF) begin
      fails++;
      $display("FAIL b2b_no_wrap: cnt=%h want F", err_count);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1), 32'($urandom),
            $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
      checks++;
      if ({awready, wready, bvalid, bresp} !== exp_bus()) begin
        fails++;
        $display("FAIL random cyc%0d: got %b want %b", i, {awready, wready, bvalid, bresp}, exp_bus());
      end
`ifdef AXIL_DECERR_STATS_EN
      checks++;
      if ({err_count, last_err_addr, err_pulse} !== {m_cnt, m_addr, m_pulse}) begin
        fails++;
        $display("FAIL random_stats cyc%0d: cnt=%h addr=%h pulse=%b want %h %h %b",
                 i, err_count, last_err_addr, err_pulse, m_cnt, m_addr, m_pulse);
      end
`endif
      step();
    end
  endtask

  initial begin
    drive(1, 0, '0, 0, 0);
    @(posedge aclk);
    @(negedge aclk);
    test_reset();
    test_same_cycle();
    test_aw_then_w();
    test_w_then_aw_stall();
    test_reset_in_resp();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
